// File: rtl/dir_input_conditioner.sv
// Direction button conditioner: synchronises, debounces and edge-detects the
// four raw N/S/E/W buttons. It turns them into registered one-hot move pulses.
// Presses that land on the same edge are rejected with a conflict pulse.
// A lone press is dropped while the game is frozen (enable low).
module dir_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic n_raw,
  input  logic s_raw,
  input  logic e_raw,
  input  logic w_raw,
  input  logic enable,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic conflict
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel order everywhere: bit 3 = north, 2 = south, 1 = east, 0 = west.
  logic [3:0] raw;
  logic [3:0] press;
  logic [3:0] dir_reg;
  logic [3:0] dir_next;
  logic       conflict_reg;
  logic       conflict_next;

  assign raw = {n_raw, s_raw, e_raw, w_raw};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic          meta_reg;
      logic          sync_reg;
      logic          stable_reg;
      logic [CW-1:0] cnt_reg;

      // Synchroniser, then a run-length counter. The stable level flips only
      // after sync has disagreed with it for DEBOUNCE_CYCLES edges in a row.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          meta_reg   <= 1'b0;
          sync_reg   <= 1'b0;
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          meta_reg <= raw[gi];
          sync_reg <= meta_reg;
          if (sync_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= ~stable_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end

      // A press is the edge on which the stable level is about to go 0 -> 1.
      // It is decoded from the toggle condition so the pulse is registered on
      // the same edge on which the stable level rises.
      assign press[gi] = (sync_reg != stable_reg) && (cnt_reg == CNT_LAST) &&
                         !stable_reg;
    end
  endgenerate

  // Arbitration: two or more presses on one edge give a conflict and no move.
  // A single press passes only while the game accepts moves.
  always_comb begin
    dir_next      = 4'b0000;
    conflict_next = 1'b0;
    if ((press & (press - 4'd1)) != 4'd0) begin
      conflict_next = 1'b1;
    end else if (enable) begin
      dir_next = press;
    end
  end

  // Output registers: every pulse lasts exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_reg      <= 4'b0000;
      conflict_reg <= 1'b0;
    end else begin
      dir_reg      <= dir_next;
      conflict_reg <= conflict_next;
    end
  end

  assign n        = dir_reg[3];
  assign s        = dir_reg[2];
  assign e        = dir_reg[1];
  assign w        = dir_reg[0];
  assign conflict = conflict_reg;

endmodule
